// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_ctrl_if: groups the pipeline request, CP0 and MMU signals of the TLB op controller.
//   master : pipeline/CP0/MMU side (drives requests, CP0 values, TLB read and probe results)
//   slave  : tlb_op_ctrl (drives handshake, CP0 update strobes, TLB read/write and probe key)
// EntryWidth is the packed width of one TLB entry (EntryHi/EntryLo0/EntryLo1/PageMask image).
interface tlb_op_ctrl_if #(
  parameter int unsigned IndexWidth = 4,
  parameter int unsigned EntryWidth = 64
);
  // Pipeline request
  logic                  op_valid;
  logic [1:0]            op_code;
  logic                  op_ready;
  // CP0 inputs
  logic [31:0]           cp0_index;
  logic [31:0]           cp0_wired;
  logic                  wired_we;
  logic [31:0]           cp0_entry_hi;
  logic [EntryWidth-1:0] cp0_wentry;
  // CP0 results
  logic [31:0]           random;
  logic                  done;
  logic [EntryWidth-1:0] rd_entry;
  logic                  rd_we;
  logic [31:0]           probe_index;
  logic                  probe_we;
  logic                  flush_req;
  // MMU read/write port
  logic [IndexWidth-1:0] tlbrw_index;
  logic                  tlbrw_we;
  logic [EntryWidth-1:0] tlbrw_wdata;
  logic [EntryWidth-1:0] tlbrw_rdata;
  // MMU probe port
  logic [31:0]           tlbp_entry_hi;
  logic [31:0]           tlbp_index;

  modport master (
    output op_valid, op_code, cp0_index, cp0_wired, wired_we, cp0_entry_hi, cp0_wentry,
           tlbrw_rdata, tlbp_index,
    input  op_ready, random, done, rd_entry, rd_we, probe_index, probe_we, flush_req,
           tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi
  );

  modport slave (
    input  op_valid, op_code, cp0_index, cp0_wired, wired_we, cp0_entry_hi, cp0_wentry,
           tlbrw_rdata, tlbp_index,
    output op_ready, random, done, rd_entry, rd_we, probe_index, probe_we, flush_req,
           tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences CP0 TLB maintenance ops (TLBR, TLBWI, TLBWR, TLBP) onto the MMU
// read/write and probe ports, owns CP0 Random and raises a flush after every TLB write.
// One op in flight; each op takes IDLE -> ISSUE -> RESP, so at most one op per 3 cycles.
// Ports:
//   clk_i   : system clock, all state on rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : tlb_op_ctrl_if.slave (request handshake, CP0 in/out, MMU rw/probe ports)
// All outputs are registered.
module tlb_op_ctrl #(
  parameter int unsigned TlbEntries = 16,
  parameter int unsigned IndexWidth = 4,
  parameter int unsigned EntryWidth = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  tlb_op_ctrl_if.slave bus
);

  localparam logic [1:0] OpTlbr  = 2'b00;
  localparam logic [1:0] OpTlbwi = 2'b01;
  localparam logic [1:0] OpTlbwr = 2'b10;
  localparam logic [1:0] OpTlbp  = 2'b11;

  localparam logic [IndexWidth-1:0] MaxIdx = IndexWidth'(TlbEntries - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q;
  logic [1:0]            op_q;
  logic                  op_ready_q;
  logic                  done_q;
  logic                  rd_we_q;
  logic                  probe_we_q;
  logic                  flush_q;
  logic                  tlbrw_we_q;
  logic [IndexWidth-1:0] tlbrw_index_q;
  logic [EntryWidth-1:0] wdata_q;
  logic [31:0]           entry_hi_q;
  logic [EntryWidth-1:0] rd_entry_q;
  logic [31:0]           probe_index_q;

  logic [IndexWidth-1:0] random_q, random_d;
  logic [IndexWidth-1:0] wired;

  // Only the low index bits of Index/Wired are meaningful.
  logic unused_cp0_hi;
  assign unused_cp0_hi = ^{bus.cp0_index[31:IndexWidth], bus.cp0_wired[31:IndexWidth]};

  assign wired = bus.cp0_wired[IndexWidth-1:0];

  // Random counts down from TlbEntries-1 to Wired and wraps; a Wired write restarts it.
  // The <= compare also pins Random at the top when Wired is at or above TlbEntries-1.
  always_comb begin
    random_d = random_q - 1'b1;
    if (bus.wired_we) begin
      random_d = MaxIdx;
    end else if (random_q <= wired) begin
      random_d = MaxIdx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      random_q <= MaxIdx;
    end else begin
      random_q <= random_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      op_q          <= OpTlbr;
      op_ready_q    <= 1'b1;
      done_q        <= 1'b0;
      rd_we_q       <= 1'b0;
      probe_we_q    <= 1'b0;
      flush_q       <= 1'b0;
      tlbrw_we_q    <= 1'b0;
      tlbrw_index_q <= '0;
      wdata_q       <= '0;
      entry_hi_q    <= '0;
      rd_entry_q    <= '0;
      probe_index_q <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      done_q     <= 1'b0;
      rd_we_q    <= 1'b0;
      probe_we_q <= 1'b0;
      flush_q    <= 1'b0;
      tlbrw_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid) begin
            op_q       <= bus.op_code;
            entry_hi_q <= bus.cp0_entry_hi;
            wdata_q    <= bus.cp0_wentry;
            // TLBWR uses the Random value of the accept cycle, before it steps.
            tlbrw_index_q <= (bus.op_code == OpTlbwr) ? random_q
                                                      : bus.cp0_index[IndexWidth-1:0];
            tlbrw_we_q <= (bus.op_code == OpTlbwi) || (bus.op_code == OpTlbwr);
            op_ready_q <= 1'b0;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (op_q == OpTlbr) begin
            rd_entry_q <= bus.tlbrw_rdata;
          end
          if (op_q == OpTlbp) begin
            probe_index_q <= bus.tlbp_index;
          end
          done_q     <= 1'b1;
          rd_we_q    <= (op_q == OpTlbr);
          probe_we_q <= (op_q == OpTlbp);
          flush_q    <= (op_q == OpTlbwi) || (op_q == OpTlbwr);
          state_q    <= StResp;
        end
        StResp: begin
          op_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: begin
          op_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign bus.op_ready      = op_ready_q;
  assign bus.random        = {{(32 - IndexWidth){1'b0}}, random_q};
  assign bus.done          = done_q;
  assign bus.rd_entry      = rd_entry_q;
  assign bus.rd_we         = rd_we_q;
  assign bus.probe_index   = probe_index_q;
  assign bus.probe_we      = probe_we_q;
  assign bus.flush_req     = flush_q;
  assign bus.tlbrw_index   = tlbrw_index_q;
  assign bus.tlbrw_we      = tlbrw_we_q;
  assign bus.tlbrw_wdata   = wdata_q;
  assign bus.tlbp_entry_hi = entry_hi_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: self-checking bench for tlb_op_ctrl. A small MMU model holds the TLB array;
// expected op results are queued at request time and checked when the DUT strobes them.
module tb_tlb_op_ctrl;

  localparam int unsigned TlbEntries = 16;
  localparam int unsigned IndexWidth = 4;
  localparam int unsigned EntryWidth = 64;

  localparam logic [1:0] OpTlbr  = 2'b00;
  localparam logic [1:0] OpTlbwi = 2'b01;
  localparam logic [1:0] OpTlbwr = 2'b10;
  localparam logic [1:0] OpTlbp  = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_op_ctrl_if #(.IndexWidth(IndexWidth), .EntryWidth(EntryWidth)) bus ();

  tlb_op_ctrl #(
    .TlbEntries(TlbEntries),
    .IndexWidth(IndexWidth),
    .EntryWidth(EntryWidth)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] preload(input int i);
    return {32'hE000_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
  endfunction

  // MMU model: TLB array, combinational read, write on tlbrw_we.
  logic [63:0] tlb_mem [TlbEntries];
  bit          mem_init = 1'b0;
  logic [31:0] probe_res = 32'h0;
  assign bus.tlbrw_rdata = tlb_mem[bus.tlbrw_index];
  assign bus.tlbp_index  = probe_res;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < TlbEntries; i++) tlb_mem[i] <= preload(i);
      mem_init <= 1'b1;
    end else if (bus.tlbrw_we) begin
      tlb_mem[bus.tlbrw_index] <= bus.tlbrw_wdata;
    end
  end

  // Reference model of CP0 Random.
  logic [3:0] m_random;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              m_random <= 4'd15;
    else if (bus.wired_we)                   m_random <= 4'd15;
    else if (m_random <= bus.cp0_wired[3:0]) m_random <= 4'd15;
    else                                     m_random <= m_random - 4'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [63:0] wdata;
    logic [31:0] ehi;
    logic [63:0] rdata;
    logic [31:0] pidx;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   we_cnt = 0;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("random", 64'(bus.random), 64'(m_random));
      if (sb_q.size() == 0) begin
        check_eq("idle_tlbrw_we", 64'(bus.tlbrw_we), 64'd0);
        check_eq("idle_done", 64'(bus.done), 64'd0);
      end else begin
        if (bus.tlbrw_we) begin
          we_cnt++;
          check_eq("wr_index", 64'(bus.tlbrw_index), 64'(sb_q[0].idx));
          check_eq("wr_wdata", bus.tlbrw_wdata, sb_q[0].wdata);
        end
        if (bus.done) begin
          mon_e = sb_q.pop_front();
          check_eq("rd_we", 64'(bus.rd_we), 64'(mon_e.op == OpTlbr));
          check_eq("probe_we", 64'(bus.probe_we), 64'(mon_e.op == OpTlbp));
          check_eq("flush_req", 64'(bus.flush_req),
                   64'(mon_e.op == OpTlbwi || mon_e.op == OpTlbwr));
          check_eq("we_cycles", 64'(we_cnt),
                   64'((mon_e.op == OpTlbwi || mon_e.op == OpTlbwr) ? 1 : 0));
          if (mon_e.op == OpTlbr) check_eq("rd_entry", bus.rd_entry, mon_e.rdata);
          if (mon_e.op == OpTlbp) begin
            check_eq("probe_index", 64'(bus.probe_index), 64'(mon_e.pidx));
            check_eq("probe_key", 64'(bus.tlbp_entry_hi), 64'(mon_e.ehi));
          end
          we_cnt = 0;
        end
      end
    end
  end

  int acc_cyc = 0;

  // Called at a falling edge; returns at the falling edge of the ISSUE cycle.
  task automatic do_op(input logic [1:0] op, input logic [3:0] idx, input logic [63:0] wentry,
                       input logic [31:0] ehi, input logic [31:0] pres, input bit hold);
    exp_t e;
    bit   acc = 1'b0;
    bus.op_code      = op;
    bus.cp0_index    = {28'hA5A5A5A, idx};
    bus.cp0_wentry   = wentry;
    bus.cp0_entry_hi = ehi;
    probe_res        = pres;
    bus.op_valid     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.op_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("accept", 64'(acc), 64'd1);
    if (acc) begin
      e.op    = op;
      e.idx   = (op == OpTlbwr) ? m_random : idx;
      e.wdata = wentry;
      e.ehi   = ehi;
      e.rdata = tlb_mem[e.idx];
      e.pidx  = pres;
      sb_q.push_back(e);
      acc_cyc = cyc;
    end
    @(negedge clk);
    if (!hold) bus.op_valid = 1'b0;
  endtask

  int  c1;
  bit  found;

  initial begin
    bus.op_valid     = 1'b0;
    bus.op_code      = 2'b00;
    bus.cp0_index    = 32'h0;
    bus.cp0_wired    = 32'h0;
    bus.wired_we     = 1'b0;
    bus.cp0_entry_hi = 32'h0;
    bus.cp0_wentry   = 64'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_op_ready", 64'(bus.op_ready), 64'd1);
    check_eq("rst_random", 64'(bus.random), 64'd15);
    check_eq("rst_strobes", 64'({bus.done, bus.rd_we, bus.probe_we, bus.flush_req,
                                 bus.tlbrw_we}), 64'd0);
    check_eq("rst_tlbrw_index", 64'(bus.tlbrw_index), 64'd0);
    check_eq("rst_wdata", bus.tlbrw_wdata, 64'd0);
    check_eq("rst_probe_key", 64'(bus.tlbp_entry_hi), 64'd0);
    check_eq("rst_rd_entry", bus.rd_entry, 64'd0);
    check_eq("rst_probe_index", 64'(bus.probe_index), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("random_free_run", 64'(bus.random), 64'd12);

    // TLBWI to entry 5
    do_op(OpTlbwi, 4'd5, 64'hDEAD_BEEF_0123_4567, 32'h0, 32'h0, 1'b0);
    check_eq("wi_we", 64'(bus.tlbrw_we), 64'd1);
    check_eq("wi_index", 64'(bus.tlbrw_index), 64'd5);
    check_eq("wi_wdata", bus.tlbrw_wdata, 64'hDEAD_BEEF_0123_4567);
    check_eq("wi_ready_issue", 64'(bus.op_ready), 64'd0);
    @(negedge clk);
    check_eq("wi_done", 64'(bus.done), 64'd1);
    check_eq("wi_flush", 64'(bus.flush_req), 64'd1);
    check_eq("wi_we_off", 64'(bus.tlbrw_we), 64'd0);
    check_eq("wi_ready_resp", 64'(bus.op_ready), 64'd0);
    @(negedge clk);
    check_eq("wi_ready_back", 64'(bus.op_ready), 64'd1);
    check_eq("wi_done_off", 64'(bus.done), 64'd0);

    // TLBR of the entry just written
    do_op(OpTlbr, 4'd5, 64'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    // Wired = 4: restart Random, then walk the full sequence
    bus.cp0_wired = 32'hFFFF_FFF4;
    bus.wired_we  = 1'b1;
    @(negedge clk);
    bus.wired_we = 1'b0;
    check_eq("wired_we_random", 64'(bus.random), 64'd15);
    for (int k = 14; k >= 4; k--) begin
      @(negedge clk);
      check_eq("random_seq", 64'(bus.random), 64'(k));
    end
    @(negedge clk);
    check_eq("random_wrap", 64'(bus.random), 64'd15);

    // TLBWR when Random is 7
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_random == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("wr_wait_random7", 64'(found), 64'd1);
    do_op(OpTlbwr, 4'd2, 64'h1111_2222_3333_4444, 32'h0, 32'h0, 1'b0);
    check_eq("wr_index7", 64'(bus.tlbrw_index), 64'd7);
    repeat (2) @(negedge clk);

    // Wired_we mid-count
    bus.wired_we = 1'b1;
    @(negedge clk);
    bus.wired_we = 1'b0;
    check_eq("wired_we_restart", 64'(bus.random), 64'd15);

    // TLBR of preloaded entry 3
    do_op(OpTlbr, 4'd3, 64'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_eq("r_done", 64'(bus.done), 64'd1);
    check_eq("r_rd_we", 64'(bus.rd_we), 64'd1);
    check_eq("r_no_flush", 64'(bus.flush_req), 64'd0);
    check_eq("r_entry3", bus.rd_entry, 64'hE000_0003_0000_1003);
    @(negedge clk);

    // TLBP miss, then hit on entry 9
    do_op(OpTlbp, 4'd0, 64'h0, 32'h1234_5000, 32'h8000_0000, 1'b0);
    @(negedge clk);
    check_eq("p_miss_we", 64'(bus.probe_we), 64'd1);
    check_eq("p_miss_idx", 64'(bus.probe_index), 64'h8000_0000);
    @(negedge clk);
    do_op(OpTlbp, 4'd0, 64'h0, 32'h0ABC_D0FF, 32'h0000_0009, 1'b0);
    @(negedge clk);
    check_eq("p_hit_idx", 64'(bus.probe_index), 64'h0000_0009);
    @(negedge clk);

    // Back-to-back TLBWI with op_valid held
    do_op(OpTlbwi, 4'd10, 64'hAAAA_0000_0000_000A, 32'h0, 32'h0, 1'b1);
    c1 = acc_cyc;
    do_op(OpTlbwi, 4'd11, 64'hBBBB_0000_0000_000B, 32'h0, 32'h0, 1'b0);
    check_eq("b2b_spacing", 64'(acc_cyc - c1), 64'd3);
    repeat (2) @(negedge clk);

    // Reset during ISSUE drops the op
    do_op(OpTlbwi, 4'd12, 64'hCCCC_0000_0000_000C, 32'h0, 32'h0, 1'b0);
    check_eq("rst_pre_we", 64'(bus.tlbrw_we), 64'd1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    we_cnt = 0;
    check_eq("rst_mid_we", 64'(bus.tlbrw_we), 64'd0);
    check_eq("rst_mid_ready", 64'(bus.op_ready), 64'd1);
    check_eq("rst_mid_random", 64'(bus.random), 64'd15);
    check_eq("rst_mid_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_ready", 64'(bus.op_ready), 64'd1);
    check_eq("post_rst_mem12", tlb_mem[12], preload(12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences CP0 TLB maintenance instructions (TLBR, TLBWI, TLBWR, TLBP) from the pipeline onto the TLB read/write and probe ports of the MMU.
- Owns the CP0 Random register and the flush request raised after every TLB write.
- Sits between the CP0/exception stage and the MMU.
- One op is in flight at a time; the pipeline stalls while op_ready is low.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries; must be a power of two.
- INDEX_WIDTH, 4, log2(TLB_ENTRIES).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- op_valid  in  1  TLB op request
- op_code  in  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
- op_ready  out  1  controller idle, accepts op
- cp0_index  in  32  CP0 Index; bits [INDEX_WIDTH-1:0] used
- cp0_wired  in  32  CP0 Wired; bits [INDEX_WIDTH-1:0] used
- wired_we  in  1  CP0 Wired being written this cycle
- cp0_entry_hi  in  32  EntryHi used for TLBP
- cp0_wentry  in  $bits(TLBEntry_t)  entry assembled from EntryHi/EntryLo0/EntryLo1/PageMask
- random  out  32  CP0 Random, zero-extended
- done  out  1  op complete pulse
- rd_entry  out  $bits(TLBEntry_t)  TLBR result, valid when rd_we
- rd_we  out  1  CP0 EntryHi/Lo/PageMask update strobe
- probe_index  out  32  TLBP result, valid when probe_we
- probe_we  out  1  CP0 Index update strobe
- flush_req  out  1  pipeline flush after TLB write
- tlbrw_index  out  INDEX_WIDTH  TLB entry index
- tlbrw_we  out  1  TLB write enable
- tlbrw_wdata  out  $bits(TLBEntry_t)  TLB write data
- tlbrw_rdata  in  $bits(TLBEntry_t)  TLB read data, combinational from tlbrw_index
- tlbp_entry_hi  out  32  probe key
- tlbp_index  in  32  probe result, combinational; bit31 set on miss

Behaviour:
- Reset values:
  - state IDLE, op_ready 1, random TLB_ENTRIES-1.
  - done, rd_we, probe_we, flush_req, tlbrw_we all 0.
  - tlbrw_index, tlbrw_wdata, tlbp_entry_hi, rd_entry, probe_index all 0.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - op_ready = 1. Accept on op_valid at a rising edge.
  - On accept, latch op_code, tlbp_entry_hi <= cp0_entry_hi, tlbrw_wdata <= cp0_wentry.
  - tlbrw_index <= cp0_index[INDEX_WIDTH-1:0] for TLBR/TLBWI/TLBP, or the current random value for TLBWR (pre-decrement value of that cycle).
- ISSUE:
  - op_ready = 0.
  - TLBWI/TLBWR: tlbrw_we = 1 for exactly this cycle.
  - TLBR: rd_entry <= tlbrw_rdata at end of cycle.
  - TLBP: probe_index <= tlbp_index at end of cycle.
- RESP:
  - op_ready = 0, done = 1 for one cycle.
  - rd_we = 1 for TLBR; probe_we = 1 for TLBP; flush_req = 1 for TLBWI/TLBWR.
  - Next state IDLE.
- Latency: accept at edge T; ISSUE in cycle T+1; done in cycle T+2. Next accept no earlier than the edge ending RESP+IDLE, i.e. max one op per 3 cycles.
- tlbrw_index, tlbrw_wdata and tlbp_entry_hi stay stable from accept through RESP.
- op_valid while op_ready = 0 is ignored; the requester holds op_valid until accepted.
- Random register (INDEX_WIDTH bits, updated every cycle):
  - wired_we = 1 → random <= TLB_ENTRIES-1 (highest priority).
  - else random <= wired → random <= TLB_ENTRIES-1.
  - else → random <= random-1.
  - Wired ≥ TLB_ENTRIES-1 pins random at TLB_ENTRIES-1.
- Reset asserted mid-op: outputs return to reset values immediately. In-flight op is dropped with no done and no further tlbrw_we.
- All outputs are registered; no combinational path from op_valid to tlbrw_*.

Test Plan:
- Reset release → op_ready=1, random=15, all strobes 0. After 3 cycles with cp0_wired=0 → random=12.
- TLBWI, cp0_index=0x5 → next cycle tlbrw_we=1 for one cycle with tlbrw_index=5 and wdata=cp0_wentry. Following cycle done=1 and flush_req=1. op_ready low for 2 cycles.
- cp0_wired=4, free-run → random sequence 15,14,…,4,15. TLBWR accepted when random=7 → tlbrw_index=7. wired_we pulse → random=15 next cycle.
- TLBR index 3 with TLB entry 3 preloaded → done and rd_we together at T+2, rd_entry = entry 3, no flush_req.
- TLBP miss: tlbp_index=0x8000_0000 → probe_we=1, probe_index=0x8000_0000. TLBP hit on entry 9 → probe_index=0x0000_0009.
- Two back-to-back TLBWI with op_valid held → second accepted only after first done. Then a TLBWI with rst low during ISSUE → tlbrw_we drops immediately, no done, state IDLE after release.
